// File: rtl/dp_fifo_ctrl_if.sv
// dp_fifo_ctrl_if: producer/consumer handshake and dp strobe bundle for dp_fifo_ctrl.
interface dp_fifo_ctrl_if #(parameter int AW = 3);
    logic        wr_req, rd_req;
    logic        wea, inca, web, incb;
    logic        rd_valid, wr_drop, full, empty;
    logic [AW:0] count;
    modport master(output wr_req, rd_req,
                   input wea, inca, web, incb, rd_valid, wr_drop, full, empty, count);
    modport slave(input wr_req, rd_req,
                  output wea, inca, web, incb, rd_valid, wr_drop, full, empty, count);
endinterface

// File: rtl/dp_fifo_ctrl.sv
// dp_fifo_ctrl: turns write/read requests into dp strobes, tracks occupancy, sequences reads as latch-then-advance.
module dp_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input logic           clk,
    input logic           rst,
    dp_fifo_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, LATCH = 2'd1, ADV = 2'd2} state_t;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    state_t      state;
    logic [AW:0] count, count_nxt;
    logic        wr_acc, pop;
    assign bus.full     = count == FULL_CNT;
    assign bus.empty    = count == '0;
    assign bus.count    = count;
    // full comes from the registered count, so a same-cycle pop never frees a slot for this write
    assign wr_acc       = bus.wr_req & ~bus.full & ~rst;
    assign bus.wr_drop  = bus.wr_req & bus.full & ~rst;
    assign bus.wea      = wr_acc;
    assign bus.inca     = wr_acc;
    assign pop          = (state == ADV) & ~rst;
    assign bus.web      = (state == LATCH) & ~rst;
    assign bus.incb     = pop;
    assign bus.rd_valid = pop;
    assign count_nxt    = count + (AW+1)'(wr_acc) - (AW+1)'(pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            count <= count_nxt;
            case (state)
                IDLE:    state <= (bus.rd_req & ~bus.empty) ? LATCH : IDLE;
                LATCH:   state <= ADV;
                ADV:     state <= (bus.rd_req && count_nxt != '0) ? LATCH : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
